// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into a 32-bit word using one of eight formats.
// A single output register with valid/ready handshake; out-of-range immediates yield 0 with out_err set.
module instr_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [10:0] opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_RSH   = 3'd1,
    FMT_I     = 3'd2,
    FMT_D     = 3'd3,
    FMT_CB    = 3'd4,
    FMT_B     = 3'd5,
    FMT_IM    = 3'd6,
    FMT_RAW   = 3'd7
  } fmt_e;

  // True when v zero-extended from its low w bits reproduces v.
  function automatic logic fits_unsigned(input logic [63:0] v, input int unsigned w);
    return ((v >> w) == 64'd0);
  endfunction

  // True when v sign-extended from its low w bits reproduces v.
  function automatic logic fits_signed(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = $unsigned($signed(v) >>> (w - 32'd1));
    return ((top == 64'd0) || (top == {64{1'b1}}));
  endfunction

  logic [31:0] instr_r;
  logic        err_r;
  logic        valid_r;
  logic [15:0] enc_count_r;
  logic [7:0]  err_count_r;

  logic [31:0] packed_s;
  logic        range_ok_s;
  logic [31:0] next_instr_s;
  logic        next_err_s;
  logic        accept_s;
  fmt_e        fmt_s;

  assign fmt_s    = fmt_e'(fmt);
  assign in_ready = !valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // Field packing and range check for the selected format.
  always_comb begin
    packed_s   = 32'h0000_0000;
    range_ok_s = 1'b1;
    case (fmt_s)
      FMT_R: begin
        packed_s   = {opcode, rm, 6'b000000, rn, rd};
        range_ok_s = 1'b1;
      end
      FMT_RSH: begin
        packed_s   = {opcode, 5'b00000, imm[5:0], rn, rd};
        range_ok_s = fits_unsigned(imm, 32'd6);
      end
      FMT_I: begin
        packed_s   = {opcode[10:1], imm[11:0], rn, rd};
        range_ok_s = fits_unsigned(imm, 32'd12);
      end
      FMT_D: begin
        packed_s   = {opcode, imm[8:0], 2'b00, rn, rd};
        range_ok_s = fits_signed(imm, 32'd9);
      end
      FMT_CB: begin
        packed_s   = {opcode[10:3], imm[18:0], rd};
        range_ok_s = fits_signed(imm, 32'd19);
      end
      FMT_B: begin
        packed_s   = {opcode[10:5], imm[25:0]};
        range_ok_s = fits_signed(imm, 32'd26);
      end
      FMT_IM: begin
        packed_s   = {opcode[10:2], 2'b00, imm[15:0], rd};
        range_ok_s = fits_unsigned(imm, 32'd16);
      end
      FMT_RAW: begin
        packed_s   = imm[31:0];
        range_ok_s = fits_unsigned(imm, 32'd32);
      end
      default: begin
        packed_s   = 32'h0000_0000;
        range_ok_s = 1'b0;
      end
    endcase
  end

  // An errored request must never leak a partially packed word.
  always_comb begin
    next_err_s = !range_ok_s;
    if (range_ok_s) begin
      next_instr_s = packed_s;
    end else begin
      next_instr_s = 32'h0000_0000;
    end
  end

  // Output register, handshake state and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
      valid_r     <= 1'b0;
      enc_count_r <= 16'h0000;
      err_count_r <= 8'h00;
    end else begin
      if (accept_s) begin
        instr_r     <= next_instr_s;
        err_r       <= next_err_s;
        valid_r     <= 1'b1;
        enc_count_r <= enc_count_r + 16'd1;
        if (next_err_s && (err_count_r != 8'hFF)) begin
          err_count_r <= err_count_r + 8'd1;
        end
      end else if (out_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign instr     = instr_r;
  assign out_err   = err_r;
  assign out_valid = valid_r;
  assign enc_count = enc_count_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed test of instr_encoder: format packing, range errors, backpressure,
// asynchronous reset and counter saturation.
module tb_instr_encoder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [10:0] opcode;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int exp_enc = 0;
  int exp_err = 0;
  logic [31:0] held;

  instr_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rn        (rn),
    .rm        (rm),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for a single accepting edge, then check the registered result.
  task automatic send(input string tag, input logic [2:0] f, input logic [10:0] op,
                      input logic [4:0] d, input logic [4:0] n, input logic [4:0] m,
                      input logic [63:0] i, input logic [31:0] exp_instr, input logic exp_e);
    in_valid = 1'b1; fmt = f; opcode = op; rd = d; rn = n; rm = m; imm = i;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_enc = (exp_enc + 1) % 65536;
    if (exp_e && exp_err < 255) exp_err++;
    chk({tag, "_instr"}, {32'd0, instr}, {32'd0, exp_instr});
    chk({tag, "_err"}, {63'd0, out_err}, {63'd0, exp_e});
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_enc"}, {48'd0, enc_count}, 64'(exp_enc));
    chk({tag, "_errcnt"}, {56'd0, err_count}, 64'(exp_err));
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = 3'd0; opcode = 11'd0; rd = 5'd0; rn = 5'd0; rm = 5'd0; imm = 64'd0;
    #3;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_enc", {48'd0, enc_count}, 64'd0);
    chk("rst_errcnt", {56'd0, err_count}, 64'd0);
    #9 reset_n = 1'b1;
    #1 chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    send("d_ldur",   3'd3, 11'h7C2, 5'd2, 5'd1, 5'd0, 64'd8,                  32'hF840_8022, 1'b0);
    send("b_m1",     3'd5, 11'h0A0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h17FF_FFFF, 1'b0);
    send("i_4096",   3'd2, 11'h488, 5'd4, 5'd3, 5'd0, 64'd4096,               32'h0000_0000, 1'b1);
    send("i_4095",   3'd2, 11'h488, 5'd4, 5'd3, 5'd0, 64'd4095,               32'h913F_FC64, 1'b0);
    send("cb_p2_18", 3'd4, 11'h5A0, 5'd5, 5'd0, 5'd0, 64'h0000_0000_0004_0000, 32'h0000_0000, 1'b1);
    send("cb_m2_18", 3'd4, 11'h5A0, 5'd5, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFC_0000, 32'hB480_0005, 1'b0);
    chk("cb_field", {45'd0, instr[23:5]}, 64'h0000_0000_0004_0000);
    send("r_add",    3'd0, 11'h458, 5'd1, 5'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 32'h8B03_0041, 1'b0);
    send("rsh_63",   3'd1, 11'h69B, 5'd1, 5'd2, 5'd0, 64'd63,                 32'hD360_FC41, 1'b0);
    send("rsh_64",   3'd1, 11'h69B, 5'd1, 5'd2, 5'd0, 64'd64,                 32'h0000_0000, 1'b1);
    send("d_m256",   3'd3, 11'h7C0, 5'd2, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FF00, 32'hF810_0022, 1'b0);
    send("d_256",    3'd3, 11'h7C0, 5'd2, 5'd1, 5'd0, 64'd256,                32'h0000_0000, 1'b1);
    send("d_m257",   3'd3, 11'h7C0, 5'd2, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FEFF, 32'h0000_0000, 1'b1);
    send("im_ffff",  3'd6, 11'h694, 5'd3, 5'd0, 5'd0, 64'h0000_0000_0000_FFFF, 32'hD29F_FFE3, 1'b0);
    send("im_10000", 3'd6, 11'h694, 5'd3, 5'd0, 5'd0, 64'h0000_0000_0001_0000, 32'h0000_0000, 1'b1);
    send("raw_ok",   3'd7, 11'h000, 5'd0, 5'd0, 5'd0, 64'h0000_0000_DEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    send("raw_hi",   3'd7, 11'h000, 5'd0, 5'd0, 5'd0, 64'h0000_0001_0000_0000, 32'h0000_0000, 1'b1);
    send("b_p2_25",  3'd5, 11'h0A0, 5'd0, 5'd0, 5'd0, 64'h0000_0000_0200_0000, 32'h0000_0000, 1'b1);
    send("b_m2_25",  3'd5, 11'h0A0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FE00_0000, 32'h1600_0000, 1'b0);

    @(posedge clk); #1;
    chk("drain_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: word held for 3 cycles while a new request waits.
    out_ready = 1'b0;
    send("bp_first", 3'd0, 11'h458, 5'd1, 5'd2, 5'd3, 64'd0, 32'h8B03_0041, 1'b0);
    held = instr;
    in_valid = 1'b1; fmt = 3'd7; imm = 64'h0000_0000_1234_5678;
    for (int c = 0; c < 3; c++) begin
      chk("bp_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      chk("bp_instr", {32'd0, instr}, {32'd0, held});
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_enc", {48'd0, enc_count}, 64'(exp_enc));
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_enc++;
    chk("b2b_instr", {32'd0, instr}, 64'h0000_0000_1234_5678);
    chk("b2b_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_enc", {48'd0, enc_count}, 64'(exp_enc));
    @(posedge clk); #1;
    chk("b2b_drain", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while a word is held.
    out_ready = 1'b0;
    send("ar_hold", 3'd2, 11'h488, 5'd4, 5'd3, 5'd0, 64'd99999, 32'h0000_0000, 1'b1);
    reset_n = 1'b0;
    #2;
    exp_enc = 0; exp_err = 0;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_err", {63'd0, out_err}, 64'd0);
    chk("ar_instr", {32'd0, instr}, 64'd0);
    chk("ar_enc", {48'd0, enc_count}, 64'd0);
    chk("ar_errcnt", {56'd0, err_count}, 64'd0);
    chk("ar_ready", {63'd0, in_ready}, 64'd1);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;

    // 256 back-to-back errored requests, then one more: err_count saturates.
    in_valid = 1'b1; fmt = 3'd7; imm = 64'h0000_0001_0000_0000;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_errcnt", {56'd0, err_count}, 64'd255);
    chk("sat_enc", {48'd0, enc_count}, 64'd256);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sat_errcnt2", {56'd0, err_count}, 64'd255);
    chk("sat_enc2", {48'd0, enc_count}, 64'd257);
    chk("sat_out_err", {63'd0, out_err}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1: request present.
REQ-004 SHALL have port in_ready, output, 1: request accepted when in_valid && in_ready at a clock edge.
REQ-005 SHALL have port fmt, input, 3: 0=R, 1=R-shift, 2=I, 3=D, 4=CB, 5=B, 6=IM, 7=RAW.
REQ-006 SHALL have port opcode, input, 11: instruction[31:21] value; each format packs only its top N bits.
REQ-007 SHALL have ports rd, rn and rm, each input, 5: rd is Rd/Rt (B.cond condition for CB), rn is Rn, rm is Rm.
REQ-008 SHALL have port imm, input, 64: full-width immediate/offset (word offset for CB/B).
REQ-009 SHALL have port out_valid, output, 1: encoded word held.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts when out_valid && out_ready.
REQ-011 SHALL have port instr, output, 32: encoded instruction.
REQ-012 SHALL have port out_err, output, 1: immediate out of range for fmt; qualifies instr.
REQ-013 SHALL have port enc_count, output, 16: accepted requests, wraps 0xFFFF->0.
REQ-014 SHALL have port err_count, output, 8: errored requests, saturates at 255.

Function
REQ-015 SHALL drive in_ready = !out_valid || out_ready (single output register, no combinational in_valid->out_valid path).
REQ-016 SHALL register instr/out_err/out_valid on acceptance; latency exactly 1 cycle.
REQ-017 SHALL hold instr, out_err and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid when the output is consumed with no new acceptance in the same cycle; simultaneous consume + accept SHALL load the new word with out_valid staying 1.
REQ-019 R: {opcode[10:0], rm, 6'b0, rn, rd}; never errors.
REQ-020 R-shift: {opcode, 5'b0, imm[5:0], rn, rd}; error if imm > 63 (unsigned).
REQ-021 I: {opcode[10:1], imm[11:0], rn, rd}; error if imm > 4095 (unsigned).
REQ-022 D: {opcode, imm[8:0], 2'b00, rn, rd}; error if imm outside -256..255 (signed).
REQ-023 CB: {opcode[10:3], imm[18:0], rd}; error if imm outside -2^18..2^18-1.
REQ-024 B: {opcode[10:5], imm[25:0]}; error if imm outside -2^25..2^25-1.
REQ-025 IM: {opcode[10:2], 2'b00, imm[15:0], rd}; error if imm > 65535 (unsigned).
REQ-026 RAW: instr = imm[31:0]; error if imm[63:32] != 0.
REQ-027 The range rule SHALL be: the packed field, extended the way decode extends it (sign for D/CB/B, zero otherwise), equals imm exactly.
REQ-028 On error, instr SHALL be 32'h0000_0000 with out_err=1; handshake proceeds normally.
REQ-029 enc_count SHALL increment on every acceptance; err_count SHALL increment on acceptance of an errored request unless already 255.

Reset
REQ-030 On reset_n low, out_valid, out_err, instr, enc_count and err_count SHALL clear to 0 immediately, asynchronously; a word held mid-backpressure SHALL be discarded.
REQ-031 in_ready SHALL be 1 while in reset and on the first edge after release.

Verification
REQ-032 fmt=3, opcode=0x7C2, imm=8, rn=1, rd=2, out_ready=1 -> next cycle instr=0xF840_8022, out_err=0, enc_count=1.
REQ-033 fmt=5, opcode=0x0A0, imm=-1 -> instr=0x17FF_FFFF, out_err=0.
REQ-034 fmt=2, opcode=0x488, imm=4096 -> instr=0, out_err=1, err_count=1; same with imm=4095 -> instr=0x913F_FC00 | (rn<<5) | rd, out_err=0.
REQ-035 fmt=4, imm=2^18 -> out_err=1; imm=-2^18 -> out_err=0, instr[23:5]=0x40000.
REQ-036 Hold out_ready=0 for 3 cycles with a word held -> in_ready=0, instr stable; raise out_ready with in_valid=1 -> back-to-back transfer, out_valid stays 1.
REQ-037 Pulse reset_n low mid-backpressure -> out_valid=0 and all counters 0 before the next edge; 256 errored requests -> err_count=255.
